// File: rtl/cache_access_sequencer.sv
// Upstream address sequencer for the cache: walks a strided address stream,
// waits on each completion pulse, and tallies accesses and hits per run.
module cache_access_sequencer #(
    parameter int unsigned        ADDR_W     = 15,
    parameter int unsigned        CNT_W      = 14,
    parameter logic [ADDR_W-1:0]  START_ADDR = 15'd1024,
    parameter logic [ADDR_W-1:0]  STRIDE     = 15'd1,
    parameter int unsigned        NUM_ACCESS = 8192,
    parameter int unsigned        TIMEOUT    = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              done_in,
    input  logic              hit_in,
    output logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic              finished,
    output logic [CNT_W-1:0]  access_count,
    output logic [CNT_W-1:0]  hit_count,
    output logic              timeout_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_GAP  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(NUM_ACCESS);
    localparam logic [7:0]       WAIT_LIMIT = 8'(TIMEOUT - 1);

    logic [1:0]       state;
    logic [7:0]       wait_cnt;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = access_count + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_IDLE;
            addr         <= START_ADDR;
            busy         <= 1'b0;
            finished     <= 1'b0;
            timeout_err  <= 1'b0;
            access_count <= '0;
            hit_count    <= '0;
            wait_cnt     <= '0;
        end else begin
            case (state)
                S_IDLE, S_FIN: begin
                    if (start) begin
                        state        <= S_GAP;
                        addr         <= START_ADDR;
                        access_count <= '0;
                        hit_count    <= '0;
                        timeout_err  <= 1'b0;
                        busy         <= 1'b1;
                        finished     <= 1'b0;
                    end
                end
                S_GAP: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    // A completion on the limit cycle takes priority over the timeout.
                    if (done_in) begin
                        access_count <= count_next;
                        if (hit_in) begin
                            hit_count <= hit_count + CNT_W'(1);
                        end
                        if (count_next == LAST_COUNT) begin
                            state    <= S_FIN;
                            busy     <= 1'b0;
                            finished <= 1'b1;
                        end else begin
                            addr  <= addr + STRIDE;
                            state <= S_GAP;
                        end
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        timeout_err <= 1'b1;
                        state       <= S_FIN;
                        busy        <= 1'b0;
                        finished    <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_access_sequencer.sv
// Scoreboard bench: stimulus plans each run with a reference model and queues
// the expected addresses and run results; a negedge monitor pops and compares.
module tb_cache_access_sequencer;

    localparam logic [14:0] T_START  = 15'h7FFC;
    localparam logic [14:0] T_STRIDE = 15'd2;
    localparam int          T_NUM    = 5;
    localparam int          T_TO     = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        done_in = 1'b0;
    logic        hit_in = 1'b0;
    logic [14:0] addr;
    logic        busy;
    logic        finished;
    logic [13:0] access_count;
    logic [13:0] hit_count;
    logic        timeout_err;

    cache_access_sequencer #(
        .ADDR_W    (15),
        .CNT_W     (14),
        .START_ADDR(T_START),
        .STRIDE    (T_STRIDE),
        .NUM_ACCESS(T_NUM),
        .TIMEOUT   (T_TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .done_in     (done_in),
        .hit_in      (hit_in),
        .addr        (addr),
        .busy        (busy),
        .finished    (finished),
        .access_count(access_count),
        .hit_count   (hit_count),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int acc;
        int hits;
        int err;
        int last_addr;
        int cycles;
        int naddr;
    } res_t;

    res_t res_q[$];
    int   addr_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT outputs against queued expectations.
    logic        rst_d = 1'b1;
    logic        busy_d = 1'b0;
    logic        fin_d = 1'b0;
    logic [14:0] addr_d = '0;
    int          cyc = 0;
    int          seen = 0;

    always @(negedge clk) begin
        if (!rst_d) begin
            chk("reset_state", {addr, busy, finished, access_count, hit_count, timeout_err},
                {T_START, 1'b0, 1'b0, 14'd0, 14'd0, 1'b0});
            seen = 0;
        end else begin
            if (busy && !busy_d) begin
                chk("start_clear", {finished, access_count, hit_count, timeout_err}, 64'd0);
                seen = 0;
                cyc = 0;
            end else begin
                cyc++;
            end
            if (busy && (!busy_d || addr != addr_d)) begin
                seen++;
                if (addr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL addr_unexpected actual=%0h expected=none", addr);
                end else begin
                    chk("addr", addr, addr_q.pop_front());
                end
            end
            if (finished && !fin_d) begin
                if (res_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL result_unexpected actual=finish expected=none");
                end else begin
                    res_t e;
                    e = res_q.pop_front();
                    chk("fin_busy", busy, 0);
                    chk("access_count", access_count, e.acc);
                    chk("hit_count", hit_count, e.hits);
                    chk("timeout_err", timeout_err, e.err);
                    chk("final_addr", addr, e.last_addr);
                    chk("run_cycles", cyc, e.cycles);
                    chk("addr_issued", seen, e.naddr);
                end
            end
        end
        rst_d  = rst;
        busy_d = busy;
        fin_d  = finished;
        addr_d = addr;
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // One access: caller sits just after the edge that entered GAP.
    task automatic drive_access(input int d, input bit h, input bit hold);
        @(posedge clk); #1 done_in = 1'b0;
        for (int k = 0; k < d; k++) begin
            start  = 1'($urandom_range(0, 1));
            hit_in = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        start   = 1'b0;
        done_in = 1'b1;
        hit_in  = h;
        @(posedge clk); #1;
        if (!hold) begin
            done_in = 1'b0;
            hit_in  = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic drive_stall();
        @(posedge clk); #1 done_in = 1'b0;
        repeat (T_TO) begin
            @(posedge clk); #1;
        end
    endtask

    // hold_mode: 0 = single-cycle done, 1 = always two cycles, 2 = random.
    task automatic do_run(input int stall_idx, input int tie_idx, input int hold_mode);
        int   dd[T_NUM];
        bit   hh[T_NUM];
        bit   ho[T_NUM];
        res_t r;
        int   n;
        r = '{acc: 0, hits: 0, err: 0, last_addr: 0, cycles: 0, naddr: 0};
        n = 0;
        for (int i = 0; i < T_NUM; i++) begin
            r.last_addr = (int'(T_START) + i * int'(T_STRIDE)) % 32768;
            addr_q.push_back(r.last_addr);
            r.naddr++;
            n++;
            if (i == stall_idx) begin
                r.err = 1;
                r.cycles += 1 + T_TO;
                break;
            end
            dd[i] = (i == tie_idx) ? T_TO - 1 : int'($urandom_range(0, 4));
            hh[i] = 1'($urandom_range(0, 1));
            ho[i] = (hold_mode == 1) ? 1'b1 : (hold_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            r.acc++;
            r.hits += int'(hh[i]);
            r.cycles += dd[i] + 2;
        end
        res_q.push_back(r);
        pulse_start();
        for (int i = 0; i < n; i++) begin
            if (i == stall_idx) drive_stall();
            else drive_access(dd[i], hh[i], ho[i]);
        end
        @(posedge clk); #1 done_in = 1'b0;
        hit_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic reset_mid_run();
        addr_q.push_back(int'(T_START));
        pulse_start();
        @(posedge clk); #1;
        repeat (3) begin
            start = 1'b1;
            @(posedge clk); #1;
        end
        start = 1'b0;
        rst   = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle", {addr, busy, finished, access_count, hit_count, timeout_err},
                {T_START, 1'b0, 1'b0, 14'd0, 14'd0, 1'b0});
        end
        do_run(-1, -1, 0);
        do_run(-1, -1, 1);
        do_run(0, -1, 0);
        do_run(-1, -1, 0);
        do_run(-1, 2, 0);
        do_run(3, -1, 2);
        reset_mid_run();
        do_run(-1, -1, 2);
        for (int j = 0; j < 6; j++) begin
            do_run(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)), 2);
        end
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("addr_q_left", addr_q.size(), 0);
        chk("res_q_left", res_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
